// File: rtl/pc_fetch_pkg.sv
// Shared encodings for the fetch stage: FSM state values and the default reset PC.
package pc_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_buf.sv
// Single-entry IF/ID output register; flush beats load, load beats drain.
// FETCH_MISALIGN_CHK_EN adds a misalign tag carried alongside pc/instr.
module pc_fetch_buf
  import pc_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               flush,
  input  logic               drain,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
`ifdef FETCH_MISALIGN_CHK_EN
  input  logic               load_mis,
  output logic               mis,
`endif
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      mis   <= 1'b0;
`endif
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
`ifdef FETCH_MISALIGN_CHK_EN
      mis   <= load_mis;
`endif
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch PC register and single-outstanding IMEM request FSM with redirect squash.
// FETCH_MISALIGN_CHK_EN adds if_misalign for redirects to unaligned targets.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic               if_misalign,
`endif
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              buf_valid;
  logic              buf_load;
  logic              buf_flush;
  logic              req_fire;
`ifdef FETCH_MISALIGN_CHK_EN
  logic              mis_q, mis_d;
`endif

  assign imem_req_valid = (state_q == FETCH_IDLE) && !buf_valid && !redirect_valid && !rst;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign if_valid       = buf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
`ifdef FETCH_MISALIGN_CHK_EN
      mis_q    <= mis_d;
`endif
    end
  end

  // Redirect overrides everything; a response landing with it is always discarded.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    mis_d     = mis_q;
`endif
    if (redirect_valid) begin
      pc_d      = redirect_pc & ~ADDR_W'(3);
      buf_flush = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
      mis_d     = |redirect_pc[1:0];
`endif
      case (state_q)
        FETCH_WAIT, FETCH_DROP: state_d = imem_rsp_valid ? FETCH_IDLE : FETCH_DROP;
        default:                state_d = FETCH_IDLE;
      endcase
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_W'(4);
            state_d  = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            buf_load = 1'b1;
            state_d  = FETCH_IDLE;
`ifdef FETCH_MISALIGN_CHK_EN
            mis_d    = 1'b0;
`endif
          end
        end
        FETCH_DROP: begin
          if (imem_rsp_valid) state_d = FETCH_IDLE;
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  pc_fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .flush      (buf_flush),
    .drain      (if_ready),
    .load_pc    (req_pc_q),
    .load_instr (imem_rsp_data),
`ifdef FETCH_MISALIGN_CHK_EN
    .load_mis   (mis_q),
    .mis        (if_misalign),
`endif
    .valid      (buf_valid),
    .pc         (if_pc),
    .instr      (if_instr)
  );

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: 0-wait IMEM model plus an expected-instruction queue.
// Build with FETCH_MISALIGN_CHK_EN to also cover the misalign tag.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        if_misalign;
`endif

  always #5 clk = ~clk;

  pc_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
`ifdef FETCH_MISALIGN_CHK_EN
    .if_misalign    (if_misalign),
`endif
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fire_log[$];
  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  bit          auto_rsp = 1'b1;
  logic        exp_mis = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // One clock: sample handshakes before the edge, then score and model IMEM after it.
  task automatic step();
    logic        fire, hs, redir_s, rst_s, hmis;
    logic [31:0] faddr, hpc, hinstr, rpc;
    exp_t        e;
    #1;
    fire    = imem_req_valid && imem_req_ready;
    faddr   = imem_req_addr;
    hs      = if_valid && if_ready;
    hpc     = if_pc;
    hinstr  = if_instr;
    hmis    = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    hmis    = if_misalign;
`endif
    redir_s = redirect_valid;
    rpc     = redirect_pc;
    rst_s   = rst;
    @(posedge clk);
    #1;
    if (hs === 1'b1) begin
      hs_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, required no transfer", hpc, hinstr);
      end else begin
        e = sb.pop_front();
        if (hpc !== e.pc || hinstr !== e.instr || hmis !== e.mis) begin
          errors++;
          $display("FAIL sb_instr: got pc=%h instr=%h mis=%b, required pc=%h instr=%h mis=%b",
                   hpc, hinstr, hmis, e.pc, e.instr, e.mis);
        end
      end
    end
    if (rst_s === 1'b1) begin
      sb.delete();
      exp_mis = 1'b0;
    end else if (redir_s === 1'b1) begin
      sb.delete();
      exp_mis = |rpc[1:0];
    end
    imem_rsp_valid = 1'b0;
    if (fire === 1'b1) begin
      fire_log.push_back(faddr);
      e.pc    = faddr;
      e.instr = instr_of(faddr);
      e.mis   = exp_mis;
      sb.push_back(e);
      exp_mis = 1'b0;
      if (auto_rsp) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(faddr);
      end
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    if_ready       = 1'b1;
    auto_rsp       = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    fire_log.delete();
    hs_count = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b1;
    repeat (2) step();
    checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req_valid=%b if_valid=%b if_pc=%h if_instr=%h, required 0 0 0 0",
               imem_req_valid, if_valid, if_pc, if_instr);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    checks++;
    if (if_misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_misalign: got %b, required 0", if_misalign);
    end
`endif
    rst = 1'b0;
    fire_log.delete();
    hs_count = 0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: got req_valid=%b addr=%h, required 1 00000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want [3] = '{32'h0, 32'h4, 32'h8};
    repeat (12) step();
    checks++;
    if (fire_log.size() < 3) begin
      errors++;
      $display("FAIL stream_fires: got %0d requests, required at least 3", fire_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (fire_log[i] !== want[i]) begin
          errors++;
          $display("FAIL stream_addr%0d: got %h, required %h", i, fire_log[i], want[i]);
        end
      end
    end
    checks++;
    if (hs_count < 3) begin
      errors++;
      $display("FAIL stream_count: got %0d instructions, required at least 3", hs_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 10 && if_valid !== 1'b1; i++) step();
    checks++;
    if (if_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: got if_valid=%b, required 1 within 10 cycles", if_valid);
    end
    repeat (5) begin
      step();
      checks++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
        errors++;
        $display("FAIL bp_hold: got req_valid=%b if_valid=%b if_pc=%h, required 0 1 00000000",
                 imem_req_valid, if_valid, if_pc);
      end
    end
    checks++;
    if (fire_log.size() != 1) begin
      errors++;
      $display("FAIL bp_fires: got %0d requests, required 1", fire_log.size());
    end
    if_ready = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0 || hs_count != 1) begin
      errors++;
      $display("FAIL bp_release: got if_valid=%b transfers=%0d, required 0 1", if_valid, hs_count);
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      errors++;
      $display("FAIL inflight_issue: got req_valid=%b addr=%h, required 1 00000008",
               imem_req_valid, imem_req_addr);
    end
    auto_rsp = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL inflight_drop_req: got req_valid=%b, required 0", imem_req_valid);
    end
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL inflight_after: got if_valid=%b req_valid=%b addr=%h, required 0 1 00000100",
               if_valid, imem_req_valid, imem_req_addr);
    end
    auto_rsp = 1'b1;
    repeat (3) step();
    checks++;
    if (hs_count != 1) begin
      errors++;
      $display("FAIL inflight_count: got %0d transfers, required 1", hs_count);
    end
  endtask

  task automatic test_redirect_with_rsp();
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL rsp_redirect: got if_valid=%b req_valid=%b addr=%h, required 0 1 00000200",
               if_valid, imem_req_valid, imem_req_addr);
    end
    repeat (3) step();
    checks++;
    if (hs_count != 1) begin
      errors++;
      $display("FAIL rsp_redirect_count: got %0d transfers, required 1", hs_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h400;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400) begin
      errors++;
      $display("FAIL b2b_redirect: got req_valid=%b addr=%h, required 1 00000400",
               imem_req_valid, imem_req_addr);
    end
    repeat (3) step();
    checks++;
    if (hs_count != 1) begin
      errors++;
      $display("FAIL b2b_count: got %0d transfers, required 1", hs_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    repeat (6) step();
    checks++;
    if (fire_log.size() < 2) begin
      errors++;
      $display("FAIL wrap_fires: got %0d requests, required at least 2", fire_log.size());
    end else if (fire_log[0] !== 32'hFFFF_FFFC || fire_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %h,%h, required fffffffc,00000000", fire_log[0], fire_log[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    step();
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_late_rsp: got if_valid=%b, required 0", if_valid);
    end
    imem_req_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (hs_count != 1) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d transfers, required 1", hs_count);
    end
  endtask

`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL mis_addr: got %h, required 00000100", imem_req_addr);
    end
    repeat (2) step();
    checks++;
    if (if_valid !== 1'b1 || if_misalign !== 1'b1) begin
      errors++;
      $display("FAIL mis_first: got if_valid=%b mis=%b, required 1 1", if_valid, if_misalign);
    end
    repeat (3) step();
    checks++;
    if (if_valid !== 1'b1 || if_misalign !== 1'b0 || if_pc !== 32'h104) begin
      errors++;
      $display("FAIL mis_second: got if_valid=%b mis=%b pc=%h, required 1 0 00000104",
               if_valid, if_misalign, if_pc);
    end
    step();
    checks++;
    if (hs_count != 2) begin
      errors++;
      $display("FAIL mis_count: got %0d transfers, required 2", hs_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
